// File: rtl/gp_sched_pkg.sv
// Shared types and constants for the gamepad poll scheduler: FSM states,
// Wishbone register addresses and CSR bit positions.
package gp_sched_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StScan    = 2'd2,
        StCapture = 2'd3
    } state_e;

    localparam logic [3:0] AddrCsr      = 4'd0;
    localparam logic [3:0] AddrInterval = 4'd1;
    localparam logic [3:0] AddrPend     = 4'd2;
    localparam logic [3:0] AddrSnap0    = 4'd4;

    localparam int unsigned CsrEnable  = 0;
    localparam int unsigned CsrTrigSrc = 1;
    localparam int unsigned CsrIrqEn   = 2;
    localparam int unsigned CsrBusy    = 8;
    localparam int unsigned CsrTimeout = 9;

endpackage

// File: rtl/gamepad_poll_sched_if.sv
// Wishbone register port of the gamepad poll scheduler.
interface gamepad_poll_sched_if;

    logic [3:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    modport master (
        output wb_addr, wb_wdata, wb_we, wb_cyc,
        input  wb_rdata, wb_ack
    );

    modport slave (
        input  wb_addr, wb_wdata, wb_we, wb_cyc,
        output wb_rdata, wb_ack
    );

endinterface

// File: rtl/gp_sched_timer.sv
// Interval timer: loads a period, counts down to zero and holds there.
module gp_sched_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        dec_i,
    input  logic [15:0] load_val_i,
    output logic        expired_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 16'd0);

endmodule

// File: rtl/gamepad_poll_sched.sv
// Gamepad poll scheduler: triggers controller scans, snapshots pad state, flags presses.
// Press-event logic (PEND, irq) is built only when GP_SCHED_EDGE_EN is defined.
module gamepad_poll_sched
    import gp_sched_pkg::*;
#(
    parameter int unsigned N_PAD     = 4,
    parameter int unsigned REG_WIDTH = 12,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    output logic                         scan_start,
    input  logic                         scan_done,
    input  logic [N_PAD*REG_WIDTH-1:0]   scan_value,
    gamepad_poll_sched_if.slave          wb,
    output logic                         irq
);

    localparam int unsigned PadBits = N_PAD * REG_WIDTH;
    localparam int unsigned ToW     = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic                 en_q, en_d, trig_src_q, trig_src_d, irq_en_q, irq_en_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          interval_q, interval_d;
    logic [PadBits-1:0]   cap_q, cap_d, snap_q, snap_d;
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;
    logic                 scan_start_q, scan_start_d;
    logic                 ack_q, ack_d, cyc_q;
    logic [31:0]          rdata_q, rdata_d, rd_mux;
    logic                 wr_en, csr_wr, int_wr, busy, trig;
    logic                 timer_load, timer_dec, timer_exp, cap_en, timeout_set;
    logic [N_PAD-1:0]     pend_q;

    assign wr_en  = ack_q & wb.wb_cyc & wb.wb_we;
    assign csr_wr = wr_en && (wb.wb_addr == AddrCsr);
    assign int_wr = wr_en && (wb.wb_addr == AddrInterval);
    assign busy   = (state_q == StScan) || (state_q == StCapture);
    assign trig   = trig_src_q ? timer_exp : tick;
    assign timer_dec = (state_q == StArmed);

    gp_sched_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .dec_i      (timer_dec),
        .load_val_i (interval_q),
        .expired_o  (timer_exp)
    );

    // Dropping enable overrides every state, so a late scan_done is never captured.
    always_comb begin
        state_d      = state_q;
        scan_start_d = 1'b0;
        to_cnt_d     = to_cnt_q;
        cap_d        = cap_q;
        cap_en       = 1'b0;
        timeout_set  = 1'b0;
        timer_load   = 1'b0;
        if (!en_q) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d    = StArmed;
                    timer_load = 1'b1;
                end
                StArmed: begin
                    if (trig) begin
                        state_d      = StScan;
                        scan_start_d = 1'b1;
                        to_cnt_d     = '0;
                    end
                end
                StScan: begin
                    if (scan_done) begin
                        state_d = StCapture;
                        cap_d   = scan_value;
                    end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
                        state_d     = StArmed;
                        timeout_set = 1'b1;
                        timer_load  = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + ToW'(1);
                    end
                end
                StCapture: begin
                    cap_en     = 1'b1;
                    state_d    = StArmed;
                    timer_load = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign snap_d = cap_en ? cap_q : snap_q;

    always_comb begin
        en_d       = en_q;
        trig_src_d = trig_src_q;
        irq_en_d   = irq_en_q;
        timeout_d  = timeout_q;
        interval_d = int_wr ? wb.wb_wdata[15:0] : interval_q;
        if (csr_wr) begin
            en_d       = wb.wb_wdata[CsrEnable];
            trig_src_d = wb.wb_wdata[CsrTrigSrc];
            irq_en_d   = wb.wb_wdata[CsrIrqEn];
            if (wb.wb_wdata[CsrTimeout]) begin
                timeout_d = 1'b0;
            end
        end
        if (timeout_set) begin
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (wb.wb_addr)
            AddrCsr: begin
                rd_mux[CsrEnable]  = en_q;
                rd_mux[CsrTrigSrc] = trig_src_q;
                rd_mux[CsrIrqEn]   = irq_en_q;
                rd_mux[CsrBusy]    = busy;
                rd_mux[CsrTimeout] = timeout_q;
            end
            AddrInterval: rd_mux[15:0] = interval_q;
            AddrPend:     rd_mux[N_PAD-1:0] = pend_q;
            default: begin
                for (int i = 0; i < N_PAD; i++) begin
                    if (wb.wb_addr == AddrSnap0 + 4'(i)) begin
                        rd_mux[REG_WIDTH-1:0] = snap_q[i*REG_WIDTH +: REG_WIDTH];
                    end
                end
            end
        endcase
    end

    // One ack per rising edge of cyc; rdata is only non-zero alongside it.
    assign ack_d   = wb.wb_cyc & ~cyc_q & ~ack_q;
    assign rdata_d = ack_d ? rd_mux : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            en_q         <= 1'b0;
            trig_src_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            timeout_q    <= 1'b0;
            interval_q   <= 16'd0;
            cap_q        <= '0;
            snap_q       <= '0;
            to_cnt_q     <= '0;
            scan_start_q <= 1'b0;
            ack_q        <= 1'b0;
            cyc_q        <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            trig_src_q   <= trig_src_d;
            irq_en_q     <= irq_en_d;
            timeout_q    <= timeout_d;
            interval_q   <= interval_d;
            cap_q        <= cap_d;
            snap_q       <= snap_d;
            to_cnt_q     <= to_cnt_d;
            scan_start_q <= scan_start_d;
            ack_q        <= ack_d;
            cyc_q        <= wb.wb_cyc;
            rdata_q      <= rdata_d;
        end
    end

`ifdef GP_SCHED_EDGE_EN
    logic [N_PAD-1:0] pend_d, pend_set;
    logic             pend_wr, irq_q;

    assign pend_wr = wr_en && (wb.wb_addr == AddrPend);

    // Hardware set is applied after the W1C mask so a coincident press survives.
    always_comb begin
        pend_set = '0;
        for (int i = 0; i < N_PAD; i++) begin
            pend_set[i] = cap_en &
                (|(cap_q[i*REG_WIDTH +: REG_WIDTH] & ~snap_q[i*REG_WIDTH +: REG_WIDTH]));
        end
        pend_d = pend_q;
        if (pend_wr) begin
            pend_d = pend_d & ~wb.wb_wdata[N_PAD-1:0];
        end
        pend_d = pend_d | pend_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= irq_en_q & (|pend_q);
        end
    end

    assign irq = irq_q;
`else
    assign pend_q = '0;
    assign irq    = 1'b0;
`endif

    assign scan_start  = scan_start_q;
    assign wb.wb_ack   = ack_q;
    assign wb.wb_rdata = rdata_q;

endmodule

// File: tb/tb_gamepad_poll_sched.sv
// Self-checking bench for gamepad_poll_sched: register vector table plus directed
// sequences for trigger, capture, timeout, interval period, W1C races and reset.
module tb_gamepad_poll_sched;
    import gp_sched_pkg::*;

    localparam int unsigned NPad = 4;
    localparam int unsigned RegW = 12;
    localparam int unsigned Tmo  = 40;
`ifdef GP_SCHED_EDGE_EN
    localparam bit EdgeOn = 1'b1;
`else
    localparam bit EdgeOn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   tick = 1'b0;
    logic                   scan_done = 1'b0;
    logic [NPad*RegW-1:0]   scan_value = '0;
    logic                   scan_start, irq;

    gamepad_poll_sched_if wb ();

    gamepad_poll_sched #(
        .N_PAD     (NPad),
        .REG_WIDTH (RegW),
        .TIMEOUT   (Tmo)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .scan_start (scan_start),
        .scan_done  (scan_done),
        .scan_value (scan_value),
        .wb         (wb),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int   n_checks = 0, n_fail = 0;
    int   cyc_cnt = 0, ss_cnt = 0;
    int   ack_viol = 0, rdata_viol = 0, irq_viol = 0;
    logic ack_prev = 1'b0;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (scan_start) ss_cnt++;
        if (wb.wb_ack && ack_prev) ack_viol++;
        ack_prev = wb.wb_ack;
        if (!wb.wb_ack && wb.wb_rdata != 32'd0) rdata_viol++;
        if (!EdgeOn && irq) irq_viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [31:0] pe(input logic [31:0] v);
        return EdgeOn ? v : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        int n;
        wb.wb_cyc = 1'b1; wb.wb_we = we; wb.wb_addr = addr; wb.wb_wdata = wdata;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!wb.wb_ack && n < 4);
        check($sformatf("wb_ack latency addr%0d", addr), 32'(n), 32'd1);
        rdata = wb.wb_rdata;
        @(posedge clk); #1;
        wb.wb_cyc = 1'b0; wb.wb_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        wb_xfer(1'b1, addr, wdata, dummy);
    endtask

    task automatic wb_read(input logic [3:0] addr, output logic [31:0] rdata);
        wb_xfer(1'b0, addr, 32'd0, rdata);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
    endtask

    task automatic pulse_done();
        scan_done = 1'b1; @(posedge clk); #1; scan_done = 1'b0;
    endtask

    task automatic wait_ss(input string name, output int at);
        int n = 0;
        while (!scan_start && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check(name, 32'(scan_start), 32'd1);
        at = cyc_cnt;
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] rd;
        int c0, c1, c2, c3, c4, ss0;

        vecs[0]  = '{1'b0, AddrCsr,      32'h0,        32'h0};
        vecs[1]  = '{1'b0, AddrInterval, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, AddrPend,     32'h0,        32'h0};
        vecs[3]  = '{1'b0, 4'd4,         32'h0,        32'h0};
        vecs[4]  = '{1'b0, 4'd7,         32'h0,        32'h0};
        vecs[5]  = '{1'b1, AddrInterval, 32'h1234ABCD, 32'h0000ABCD};
        vecs[6]  = '{1'b1, AddrCsr,      32'h00000106, 32'h00000006};
        vecs[7]  = '{1'b1, 4'd3,         32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{1'b1, 4'd5,         32'h00000FFF, 32'h0};
        vecs[9]  = '{1'b1, AddrPend,     32'h0000000F, 32'h0};
        vecs[10] = '{1'b1, AddrCsr,      32'h0,        32'h0};
        vecs[11] = '{1'b0, 4'd8,         32'h0,        32'h0};
        vecs[12] = '{1'b1, AddrInterval, 32'h0,        32'h0};

        wb.wb_cyc = 1'b0; wb.wb_we = 1'b0; wb.wb_addr = 4'd0; wb.wb_wdata = 32'd0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("reset scan_start", 32'(scan_start), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        check("reset wb_ack", 32'(wb.wb_ack), 32'd0);
        check("reset wb_rdata", wb.wb_rdata, 32'd0);
        step(3);
        rst_n = 1'b1;
        step(2);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) wb_write(vecs[i].addr, vecs[i].wdata);
            wb_read(vecs[i].addr, rd);
            check($sformatf("vec%0d addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
        end

        // Tick trigger and first capture
        wb_write(AddrCsr, 32'h1);
        step(2);
        ss0 = ss_cnt;
        check("no scan_start while armed", 32'(scan_start), 32'd0);
        pulse_tick();
        check("scan_start one cycle after tick", 32'(scan_start), 32'd1);
        step(1);
        check("scan_start single pulse", 32'(scan_start), 32'd0);
        pulse_tick();
        step(5);
        check("tick during SCAN dropped", 32'(ss_cnt - ss0), 32'd1);
        wb_read(AddrCsr, rd);
        check("busy in SCAN", rd, 32'h101);
        scan_value[11:0] = 12'h001;
        pulse_done();
        step(3);
        wb_read(4'd4, rd);
        check("snapshot pad0 after scan", rd, 32'h001);
        wb_read(AddrPend, rd);
        check("PEND after first press", rd, pe(32'h1));
        wb_read(AddrCsr, rd);
        check("CSR idle-armed after capture", rd, 32'h001);
        check("irq masked by irq_en", 32'(irq), 32'd0);

        // irq, then W1C landing in the CAPTURE cycle of a new press
        wb_write(AddrCsr, 32'h5);
        step(2);
        check("irq with PEND set", 32'(irq), pe(32'h1));
        pulse_tick();
        check("scan_start before race", 32'(scan_start), 32'd1);
        wb.wb_cyc = 1'b1; wb.wb_we = 1'b1; wb.wb_addr = AddrPend; wb.wb_wdata = 32'h1;
        scan_value[11:0] = 12'h003;
        scan_done = 1'b1;
        @(posedge clk); #1;
        scan_done = 1'b0;
        check("race ack", 32'(wb.wb_ack), 32'd1);
        @(posedge clk); #1;
        wb.wb_cyc = 1'b0; wb.wb_we = 1'b0;
        @(posedge clk); #1;
        wb_read(AddrPend, rd);
        check("PEND set wins over W1C", rd, pe(32'h1));
        wb_read(4'd4, rd);
        check("snapshot pad0 second scan", rd, 32'h003);
        wb_write(AddrPend, 32'h1);
        wb_read(AddrPend, rd);
        check("PEND W1C clears", rd, 32'h0);
        check("irq drops after clear", 32'(irq), 32'd0);

        // Press on pad2 only
        pulse_tick();
        scan_value[35:24] = 12'h800;
        pulse_done();
        step(3);
        wb_read(AddrPend, rd);
        check("PEND pad2 press", rd, pe(32'h4));
        wb_read(4'd6, rd);
        check("snapshot pad2", rd, 32'h800);
        wb_write(AddrPend, 32'hF);
        wb_read(AddrPend, rd);
        check("PEND cleared all", rd, 32'h0);

        // Timeout without scan_done
        pulse_tick();
        check("scan_start for timeout scan", 32'(scan_start), 32'd1);
        step(20);
        wb_read(AddrCsr, rd);
        check("busy before timeout", rd, 32'h105);
        step(30);
        wb_read(AddrCsr, rd);
        check("timeout sticky, back to ARMED", rd, 32'h205);
        wb_read(4'd4, rd);
        check("snapshot pad0 kept on timeout", rd, 32'h003);
        wb_read(4'd6, rd);
        check("snapshot pad2 kept on timeout", rd, 32'h800);
        pulse_tick();
        check("re-armed after timeout", 32'(scan_start), 32'd1);
        wb_write(AddrCsr, 32'h205);
        wb_read(AddrCsr, rd);
        check("timeout W1C", rd, 32'h105);
        pulse_done();
        step(3);

        // Timeout set coinciding with W1C: ack cycle is the last SCAN cycle
        pulse_tick();
        check("scan_start for timeout race", 32'(scan_start), 32'd1);
        repeat (Tmo - 2) @(posedge clk);
        #1;
        wb.wb_cyc = 1'b1; wb.wb_we = 1'b1; wb.wb_addr = AddrCsr; wb.wb_wdata = 32'h205;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb.wb_cyc = 1'b0; wb.wb_we = 1'b0;
        @(posedge clk); #1;
        wb_read(AddrCsr, rd);
        check("timeout set wins over W1C", rd, 32'h205);
        wb_write(AddrCsr, 32'h205);
        wb_read(AddrCsr, rd);
        check("timeout cleared again", rd, 32'h005);

        // Interval timer: period = (k+1) SCAN + 1 CAPTURE + (INTERVAL+1) ARMED cycles
        wb_write(AddrInterval, 32'd10);
        wb_write(AddrCsr, 32'h3);
        wait_ss("interval first scan", c0);
        repeat (3) @(posedge clk);
        #1;
        pulse_done();
        wait_ss("interval second scan", c1);
        check("interval period k=3", 32'(c1 - c0), 32'd16);
        pulse_done();
        wait_ss("interval third scan", c2);
        check("interval period k=0", 32'(c2 - c1), 32'd13);
        pulse_done();
        wb_write(AddrInterval, 32'd0);
        wait_ss("interval0 first scan", c3);
        pulse_done();
        wait_ss("interval0 second scan", c4);
        check("INTERVAL=0 period", 32'(c4 - c3), 32'd3);

        // Disable mid-SCAN: late scan_done ignored, no further scans
        wb_write(AddrCsr, 32'h0);
        scan_value[11:0] = 12'hFFF;
        pulse_done();
        step(3);
        wb_read(4'd4, rd);
        check("scan_done ignored when disabled", rd, 32'h003);
        ss0 = ss_cnt;
        step(20);
        check("no scan_start when disabled", 32'(ss_cnt - ss0), 32'd0);
        wb_read(AddrCsr, rd);
        check("CSR after disable", rd, 32'h0);

        // Reset asserted mid-SCAN while ack, scan_start and irq are all high
        wb_write(AddrCsr, 32'h5);
        step(2);
        pulse_tick();
        scan_value[23:12] = 12'h010;
        pulse_done();
        step(3);
        tick = 1'b1;
        wb.wb_cyc = 1'b1; wb.wb_we = 1'b0; wb.wb_addr = 4'd6;
        @(posedge clk); #1;
        tick = 1'b0;
        check("pre-reset scan_start", 32'(scan_start), 32'd1);
        check("pre-reset wb_ack", 32'(wb.wb_ack), 32'd1);
        check("pre-reset wb_rdata", wb.wb_rdata, 32'h800);
        check("pre-reset irq", 32'(irq), pe(32'h1));
        #2 rst_n = 1'b0;
        #1;
        check("reset scan_start immediate", 32'(scan_start), 32'd0);
        check("reset wb_ack immediate", 32'(wb.wb_ack), 32'd0);
        check("reset wb_rdata immediate", wb.wb_rdata, 32'd0);
        check("reset irq immediate", 32'(irq), 32'd0);
        wb.wb_cyc = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        wb_read(AddrCsr, rd);
        check("CSR after reset", rd, 32'h0);
        wb_read(AddrInterval, rd);
        check("INTERVAL after reset", rd, 32'h0);
        wb_read(4'd6, rd);
        check("snapshot after reset", rd, 32'h0);
        ss0 = ss_cnt;
        pulse_tick();
        step(10);
        check("no scan_start after reset", 32'(ss_cnt - ss0), 32'd0);

        check("wb_ack never on consecutive cycles", 32'(ack_viol), 32'd0);
        check("wb_rdata zero outside ack", 32'(rdata_viol), 32'd0);
        check("irq tied low without edge build", 32'(irq_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
